// File: rtl/uart_pkg.sv
// UART transmit shared types and helpers.
// Frame state encoding, data-bit codes and parity function.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    localparam int MAX_BITS = 8;

    function automatic logic calc_parity(
        input logic [MAX_BITS-1:0] data,
        input logic [1:0]          dbits,
        input logic                odd
    );
        logic p;
        p = odd;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < 5 + int'(dbits)) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, 5-8 data bits, parity, stop.
// One bit per tx_tick; config is snapshotted at byte acceptance.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_tick,
    input  logic [1:0]            cfg_data_bits,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_parity_odd,
    input  logic                  cfg_stop2,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    tx_state_e             state, state_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic [2:0]            bit_cnt, bit_cnt_n;
    logic [2:0]            last_bit, last_bit_n;
    logic                  stop_cnt, stop_cnt_n;
    logic                  par_en_q, par_en_n;
    logic                  par_bit_q, par_bit_n;
    logic                  stop2_q, stop2_n;
    logic                  tx_q, tx_n;
    logic                  done_q, done_n;

    logic [2:0]            cfg_last_bit;
    logic [MAX_BITS-1:0]   data8;
    logic                  last_stop;
    logic                  accept;

    assign data8     = MAX_BITS'(tx_data);
    assign last_stop = !stop2_q || stop_cnt;
    assign tx_ready  = (state == IDLE) ||
                       (state == STOP && last_stop && tx_tick);
    assign accept    = tx_valid && tx_ready;

    assign tx      = tx_q;
    assign tx_busy = (state != IDLE);
    assign tx_done = done_q;

    // Index of the final data bit for the offered configuration.
    always_comb begin
        cfg_last_bit = 3'd7;
        unique case (cfg_data_bits)
            DBITS_5: cfg_last_bit = 3'd4;
            DBITS_6: cfg_last_bit = 3'd5;
            DBITS_7: cfg_last_bit = 3'd6;
            DBITS_8: cfg_last_bit = 3'd7;
        endcase
    end

    // Next-state, next line value and snapshot capture.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        last_bit_n = last_bit;
        stop_cnt_n = stop_cnt;
        par_en_n   = par_en_q;
        par_bit_n  = par_bit_q;
        stop2_n    = stop2_q;
        tx_n       = tx_q;
        done_n     = 1'b0;

        if (accept) begin
            shreg_n    = tx_data;
            last_bit_n = cfg_last_bit;
            par_en_n   = cfg_parity_en;
            par_bit_n  = calc_parity(data8, cfg_data_bits,
                                     cfg_parity_odd);
            stop2_n    = cfg_stop2;
        end

        unique case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (accept) begin
                    state_n = SYNC;
                end
            end
            SYNC: begin
                if (tx_tick) begin
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (tx_tick) begin
                    state_n   = DATA;
                    tx_n      = shreg[0];
                    bit_cnt_n = 3'd0;
                end
            end
            DATA: begin
                if (tx_tick) begin
                    if (bit_cnt < last_bit) begin
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg[1];
                        bit_cnt_n = bit_cnt + 3'd1;
                    end else if (par_en_q) begin
                        state_n = PARITY;
                        tx_n    = par_bit_q;
                    end else begin
                        state_n    = STOP;
                        tx_n       = 1'b1;
                        stop_cnt_n = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (tx_tick) begin
                    state_n    = STOP;
                    tx_n       = 1'b1;
                    stop_cnt_n = 1'b0;
                end
            end
            STOP: begin
                if (tx_tick) begin
                    if (last_stop) begin
                        done_n = 1'b1;
                        if (accept) begin
                            state_n = START;
                            tx_n    = 1'b0;
                        end else begin
                            state_n = IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= 3'd0;
            last_bit  <= 3'd0;
            stop_cnt  <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            last_bit  <= last_bit_n;
            stop_cnt  <= stop_cnt_n;
            par_en_q  <= par_en_n;
            par_bit_q <= par_bit_n;
            stop2_q   <= stop2_n;
            tx_q      <= tx_n;
            done_q    <= done_n;
        end
    end

endmodule
